// File: rtl/tone_decoder_if.sv
// Bus between the tone decoder and its consumer: the tone input and the decoded note reports.
interface tone_decoder_if;
    logic       tone_in;
    logic [3:0] note_code;
    logic       note_valid;
    logic       note_active;
    logic       silence_pulse;

    modport master (
        output tone_in,
        input  note_code, note_valid, note_active, silence_pulse
    );

    modport slave (
        input  tone_in,
        output note_code, note_valid, note_active, silence_pulse
    );
endinterface

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone and decodes it to a sequencer note code (1..10),
// reporting each newly confirmed note once and the return to silence.
module tone_decoder #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int TOL_SHIFT      = 6,
    parameter int MATCH_COUNT    = 3,
    parameter int SILENCE_CYCLES = CLK_FREQ / 100
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2} state_t;

    // One cycle of registering follows the compare, so firing two counts early puts the
    // silence pulse exactly SILENCE_CYCLES after the last edge.
    localparam logic [17:0] TIMEOUT_AT = 18'(SILENCE_CYCLES - 2);
    localparam logic [2:0]  MATCH_N    = 3'(MATCH_COUNT);

    // Period table in 25 MHz cycles, rescaled to the actual clock.
    function automatic logic [17:0] nominal(input logic [3:0] k);
        logic [63:0] base;
        case (k)
            4'd1:    base = 64'd23889;
            4'd2:    base = 64'd21283;
            4'd3:    base = 64'd18961;
            4'd4:    base = 64'd17897;
            4'd5:    base = 64'd15944;
            4'd6:    base = 64'd12655;
            4'd7:    base = 64'd11945;
            4'd8:    base = 64'd31888;
            4'd9:    base = 64'd71586;
            4'd10:   base = 64'd101240;
            default: base = 64'd0;
        endcase
        nominal = 18'((base * 64'(CLK_FREQ)) / 64'd25_000_000);
    endfunction

    function automatic logic [3:0] classify(input logic [18:0] period);
        logic [18:0] nom;
        logic [18:0] tol;
        classify = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            nom = {1'b0, nominal(4'(k))};
            tol = nom >> TOL_SHIFT;
            if ((period >= (nom - tol)) && (period <= (nom + tol))) begin
                classify = 4'(k);
            end else begin
                classify = classify;
            end
        end
    endfunction

    logic [1:0]  sync_r;
    logic        sync_d_r;
    logic        edge_r;
    logic [17:0] cnt_r;
    logic        cls_r;
    logic [3:0]  code_r;
    logic [3:0]  cand_r;
    logic [2:0]  run_r;
    state_t      state_r;
    state_t      state_nx_s;
    logic [3:0]  cand_nx_s;
    logic [2:0]  run_nx_s;
    logic        confirm_s;
    logic        new_note_s;
    logic        timeout_s;
    logic        edge_s;
    logic [3:0]  note_code_r, note_code_nx_s;
    logic        note_valid_r, note_valid_nx_s;
    logic        note_active_r, note_active_nx_s;
    logic        silence_pulse_r, silence_pulse_nx_s;

    assign edge_s    = sync_r[1] & ~sync_d_r;
    assign timeout_s = (state_r != IDLE) && !edge_r && (cnt_r >= TIMEOUT_AT);

    // Synchroniser and registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 2'b00;
            sync_d_r <= 1'b0;
            edge_r   <= 1'b0;
        end else begin
            sync_r   <= {sync_r[0], bus.tone_in};
            sync_d_r <= sync_r[1];
            edge_r   <= edge_s;
        end
    end

    // Period counter and one-cycle-late classification of the finished period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 18'd0;
            cls_r  <= 1'b0;
            code_r <= 4'd0;
        end else begin
            if ((state_r == IDLE) || edge_r) begin
                cnt_r <= 18'd0;
            end else if (cnt_r != 18'h3FFFF) begin
                cnt_r <= cnt_r + 18'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            cls_r  <= edge_r && (state_r != IDLE);
            code_r <= edge_r ? classify({1'b0, cnt_r} + 19'd1) : code_r;
        end
    end

    // Candidate tracking: run counts consecutive identical nonzero codes.
    always_comb begin
        cand_nx_s = cand_r;
        run_nx_s  = run_r;
        if (cls_r) begin
            if ((code_r == cand_r) && (code_r != 4'd0)) begin
                run_nx_s = (run_r != 3'd7) ? (run_r + 3'd1) : run_r;
            end else begin
                cand_nx_s = code_r;
                run_nx_s  = (code_r != 4'd0) ? 3'd1 : 3'd0;
            end
        end else begin
            run_nx_s = run_r;
        end
        confirm_s  = cls_r && (run_nx_s == MATCH_N);
        new_note_s = confirm_s && (cand_nx_s != note_code_r);
    end

    // State register plus candidate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cand_r  <= 4'd0;
            run_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            cand_r  <= timeout_s ? 4'd0 : cand_nx_s;
            run_r   <= timeout_s ? 3'd0 : run_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = edge_r ? ARM : IDLE;
            ARM: begin
                if (timeout_s)      state_nx_s = IDLE;
                else if (confirm_s) state_nx_s = TRACK;
                else                state_nx_s = ARM;
            end
            TRACK:   state_nx_s = timeout_s ? IDLE : TRACK;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output logic; timeout and a new note are exclusive, so the two pulses never coincide.
    always_comb begin
        note_code_nx_s     = note_code_r;
        note_valid_nx_s    = 1'b0;
        note_active_nx_s   = note_active_r;
        silence_pulse_nx_s = 1'b0;
        if (timeout_s) begin
            note_code_nx_s     = 4'd0;
            note_active_nx_s   = 1'b0;
            silence_pulse_nx_s = note_active_r;
        end else if (new_note_s) begin
            note_code_nx_s   = cand_nx_s;
            note_valid_nx_s  = 1'b1;
            note_active_nx_s = 1'b1;
        end else if (confirm_s) begin
            note_active_nx_s = 1'b1;
        end else begin
            note_active_nx_s = note_active_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_code_r     <= 4'd0;
            note_valid_r    <= 1'b0;
            note_active_r   <= 1'b0;
            silence_pulse_r <= 1'b0;
        end else begin
            note_code_r     <= note_code_nx_s;
            note_valid_r    <= note_valid_nx_s;
            note_active_r   <= note_active_nx_s;
            silence_pulse_r <= silence_pulse_nx_s;
        end
    end

    assign bus.note_code     = note_code_r;
    assign bus.note_valid    = note_valid_r;
    assign bus.note_active   = note_active_r;
    assign bus.silence_pulse = silence_pulse_r;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder run at a 500 kHz clock, so every nominal period is the
// 25 MHz table value divided by 50 (rounded down) and the silence timeout is 5000 cycles.
module tb_tone_decoder;
    localparam int S       = 5000;
    localparam int P_C6    = 477;
    localparam int P_G6    = 318;
    localparam int P_C7    = 238;
    localparam int P_F4    = 1431;
    localparam int P_B3    = 2024;
    localparam int P_GAP   = 400;
    localparam int LAT     = 5;
    localparam int SIL_LAT = S + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    tone_decoder_if bus();

    tone_decoder #(.CLK_FREQ(500_000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int valid_n = 0;
    int sil_n = 0;
    int both_n = 0;
    int valid_cyc = 0;
    int sil_cyc = 0;
    logic [3:0] valid_code [0:15];
    int rises[$];
    int v0;
    int s0;

    always @(negedge clk) begin
        if (bus.note_valid) begin
            if (valid_n < 16) valid_code[valid_n] = bus.note_code;
            valid_n   = valid_n + 1;
            valid_cyc = cyc;
        end
        if (bus.silence_pulse) begin
            sil_n   = sil_n + 1;
            sil_cyc = cyc;
        end
        if (bus.note_valid && bus.silence_pulse) both_n = both_n + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One tone period of p cycles starting with a rising edge.
    task automatic period(input int p);
        @(negedge clk);
        bus.tone_in = 1'b1;
        rises.push_back(cyc);
        repeat (p / 2) @(negedge clk);
        bus.tone_in = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_silence(input int limit);
        int start;
        start = sil_n;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (sil_n != start) break;
        end
        #1;
    endtask

    initial begin
        bus.tone_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_code", int'(bus.note_code), 0);
        chk("rst_valid", int'(bus.note_valid), 0);
        chk("rst_active", int'(bus.note_active), 0);
        chk("rst_silence", int'(bus.silence_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(5);

        // 1: G6 for 10 periods
        v0 = valid_n; s0 = sil_n; rises.delete();
        repeat (10) period(P_G6);
        settle(10);
        chk("t1_valid_cnt", valid_n - v0, 1);
        chk("t1_code", int'(valid_code[v0]), 5);
        chk("t1_latency", valid_cyc - rises[3], LAT);
        chk("t1_active", int'(bus.note_active), 1);
        wait_silence(S + 100);
        chk("t1_sil_cnt", sil_n - s0, 1);
        chk("t1_code_after", int'(bus.note_code), 0);

        // 2: G6 then C7 without silence
        v0 = valid_n; s0 = sil_n; rises.delete();
        repeat (6) period(P_G6);
        repeat (6) period(P_C7);
        settle(10);
        chk("t2_valid_cnt", valid_n - v0, 2);
        chk("t2_code_first", int'(valid_code[v0]), 5);
        chk("t2_code_second", int'(valid_code[v0 + 1]), 7);
        chk("t2_no_sil", sil_n - s0, 0);
        chk("t2_code_now", int'(bus.note_code), 7);
        wait_silence(S + 100);
        chk("t2_sil_cnt", sil_n - s0, 1);

        // 3: B3 then stuck low
        v0 = valid_n; s0 = sil_n; rises.delete();
        repeat (4) period(P_B3);
        settle(10);
        chk("t3_code", int'(bus.note_code), 10);
        chk("t3_valid_cnt", valid_n - v0, 1);
        wait_silence(S + 100);
        chk("t3_sil_cnt", sil_n - s0, 1);
        chk("t3_sil_time", sil_cyc - rises[3], SIL_LAT);
        chk("t3_code_after", int'(bus.note_code), 0);
        chk("t3_active_after", int'(bus.note_active), 0);

        // 4: period between windows
        v0 = valid_n; s0 = sil_n; rises.delete();
        repeat (8) period(P_GAP);
        settle(5);
        chk("t4_active", int'(bus.note_active), 0);
        settle(S + 100);
        chk("t4_valid_cnt", valid_n - v0, 0);
        chk("t4_sil_cnt", sil_n - s0, 0);

        // 5: jitter on C6, one out-of-window period, then silent reconfirm
        v0 = valid_n; s0 = sil_n; rises.delete();
        period(P_C6 + 6);
        period(P_C6 - 6);
        period(P_C6 + 6);
        period(P_C6 + 8);
        repeat (4) period(P_C6);
        settle(10);
        chk("t5_valid_cnt", valid_n - v0, 1);
        chk("t5_code", int'(valid_code[v0]), 1);
        chk("t5_latency", valid_cyc - rises[3], LAT);
        chk("t5_active", int'(bus.note_active), 1);
        wait_silence(S + 100);
        chk("t5_sil_cnt", sil_n - s0, 1);

        // 6: reset while F4 is active
        v0 = valid_n; rises.delete();
        repeat (4) period(P_F4);
        settle(10);
        chk("t6_code_pre", int'(bus.note_code), 9);
        chk("t6_active_pre", int'(bus.note_active), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_code", int'(bus.note_code), 0);
        chk("t6_rst_active", int'(bus.note_active), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_n; s0 = sil_n; rises.delete();
        repeat (4) period(P_F4);
        settle(10);
        chk("t6_valid_cnt", valid_n - v0, 1);
        chk("t6_code", int'(valid_code[v0]), 9);
        chk("t6_latency", valid_cyc - rises[3], LAT);
        wait_silence(S + 100);
        chk("t6_sil_cnt", sil_n - s0, 1);

        chk("never_both_pulses", both_n, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
